lsu_rdata_mux_8to1: RTL and testbench
=====================================

Name: lsu_rdata_mux_8to1

Overview:
- Return path for the LSU's 8-region write/request demux. Collects read data from one of 8 memory regions and returns it to the LSU pipeline.
- Per load: latches region select, byte offset, size and signedness; waits for the selected region's data-valid; extracts and sign/zero-extends the addressed lane.
- Presents a registered response on a valid/ready handshake.
- One outstanding load at a time.

Parameters:
- DATA_W, 32, data width of each region port and of the response (only 32 supported).
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit; used only with LSU_RMUX_TIMEOUT_EN; legal range 1..65535.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- req_valid_i  input  1  load request valid
- req_ready_o  output  1  block can accept a request
- sel_i  input  3  region index 0..7
- byte_off_i  input  2  address bits [1:0]
- size_i  input  2  0=byte, 1=half, 2=word, 3=treated as word
- unsigned_i  input  1  1=zero-extend, 0=sign-extend
- data_i  input  [7:0][31:0]  per-region read data
- data_valid_i  input  8  per-region read data valid (single-cycle pulse)
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  LSU accepts response
- rsp_data_o  output  32  extracted, extended load data
- rsp_err_o  output  1  timeout error flag

Behaviour:
- Reset (async, any state): state=IDLE. req_ready_o=1 combinationally in IDLE. rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, all latched fields and counter =0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch sel, off, size, unsigned; go to WAIT.
  - data_valid_i is ignored in IDLE.
- WAIT:
  - req_ready_o=0.
  - On data_valid_i[sel_q]=1: register extracted data into rsp_data_o; go to RESP. rsp_valid_o rises the next cycle.
  - Valids on other lanes are ignored and dropped.
  - If data_valid_i[sel_q] is high in the same cycle the request is accepted, it is ignored; capture happens only in WAIT.
- RESP:
  - rsp_valid_o=1. rsp_data_o and rsp_err_o are held stable until rsp_ready_i.
  - On handshake: go to IDLE, rsp_valid_o=0 next cycle.
  - No new request is accepted in the handshake cycle.
- Minimum latency: request accepted at cycle N, data_valid at N+1, rsp_valid_o at N+2.
- Extraction of word w:
  - byte: w >> (8*off)[7:0]
  - half: w >> (16*off[1])[15:0]; off[0] is ignored (aligned down)
  - word: off is ignored
- Extension: unsigned_i=1 fills upper bits with 0; otherwise fills with the MSB of the extracted field. Word loads have no extension.
- Reset while in WAIT or RESP: the response is discarded; a late data_valid after reset is ignored, since the FSM is in IDLE.

Optional Feature:
- Macro: LSU_RMUX_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on entry to WAIT, incremented each WAIT cycle.
  - When count==TIMEOUT_CYCLES-1 without the selected valid: go to RESP with rsp_data_o=0 and rsp_err_o=1.
  - rsp_err_o clears on the RESP handshake.
  - A valid arriving in the same cycle as expiry wins: normal data, err=0.
- Undefined: no counter; WAIT holds indefinitely; rsp_err_o tied to 0.

Decomposition:
- Shared package lsu_pkg:
  - typedef enum logic [1:0] load_size_e {LS_BYTE, LS_HALF, LS_WORD, LS_RSVD}
  - typedef enum for rmux state {RM_IDLE, RM_WAIT, RM_RESP}
  - localparam LSU_NUM_REGIONS=8
  - localparam LSU_DATA_W=32
- One combinational sub-module, load_extract (inputs: word, off, size, unsigned; output: 32-bit result), reusable by other load paths.
- FSM, latches and counter stay in the top module.

Test Plan:
- Word load: sel=3, size=2, region 3 returns 32'hCAFE_1234 one cycle later, rsp_ready_i=1 -> rsp_data_o=32'hCAFE_1234 at N+2, single-cycle rsp_valid_o, then req_ready_o=1.
- Signed byte: sel=5, off=2, size=0, unsigned=0, data=32'h0080_FF00 -> 32'hFFFF_FF80. Same with unsigned=1 -> 32'h0000_0080.
- Half, misaligned and wrong-lane noise: sel=1, off=3, size=1, unsigned=0, data=32'h8001_7FFF -> 32'hFFFF_8001. A data_valid_i[2] pulse during WAIT changes nothing.
- Backpressure: rsp_ready_i low for 5 cycles in RESP -> rsp_valid_o and data stable for 5 cycles; req_valid_i during RESP is not accepted.
- Async reset mid-WAIT: assert rst_i between clock edges -> outputs 0 immediately. data_valid_i[sel] after release produces no response.
- With LSU_RMUX_TIMEOUT_EN and TIMEOUT_CYCLES=4: no data_valid -> RESP after 4 WAIT cycles, rsp_err_o=1, data=0. A valid on the 4th cycle -> err=0 and correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU types and constants: load size encoding, read-mux FSM states,
// region count and datapath width.
package lsu_pkg;

  localparam int LSU_NUM_REGIONS = 8;
  localparam int LSU_DATA_W      = 32;

  typedef enum logic [1:0] {LS_BYTE, LS_HALF, LS_WORD, LS_RSVD} load_size_e;

  typedef enum logic [1:0] {RM_IDLE, RM_WAIT, RM_RESP} rmux_state_e;

endpackage

// File: rtl/load_extract.sv
// Lane extraction plus sign/zero extension of a 32-bit read word.
// Purely combinational so other load return paths can share it.
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  load_size_e  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    // halfwords align down: only off[1] picks the lane
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (size_i)
      LS_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      LS_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_rdata_mux_8to1.sv
// LSU read-data return mux: one outstanding load, waits for the selected
// region's valid, returns extracted data. Optional LSU_RMUX_TIMEOUT_EN.
module lsu_rdata_mux_8to1
  import lsu_pkg::*;
#(
  parameter int DATA_W         = LSU_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [2:0]                             sel_i,
  input  logic [1:0]                             byte_off_i,
  input  logic [1:0]                             size_i,
  input  logic                                   unsigned_i,
  input  logic [LSU_NUM_REGIONS-1:0][DATA_W-1:0] data_i,
  input  logic [LSU_NUM_REGIONS-1:0]             data_valid_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [DATA_W-1:0]                      rsp_data_o,
  output logic                                   rsp_err_o
);

  if (DATA_W != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("lsu_rdata_mux_8to1: unsupported DATA_W or TIMEOUT_CYCLES");
  end

  rmux_state_e state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  off_q, off_d;
  load_size_e  size_q, size_d;
  logic        uns_q, uns_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] ext_data;
  logic        sel_valid;

`ifdef LSU_RMUX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  load_extract u_extract (
    .word_i     (data_i[sel_q]),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  assign sel_valid = data_valid_i[sel_q];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rsp_data_d = rsp_data_q;
`ifdef LSU_RMUX_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      RM_IDLE: begin
        if (req_valid_i) begin
          sel_d   = sel_i;
          off_d   = byte_off_i;
          size_d  = load_size_e'(size_i);
          uns_d   = unsigned_i;
          state_d = RM_WAIT;
`ifdef LSU_RMUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RM_WAIT: begin
`ifdef LSU_RMUX_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        // a valid in the expiry cycle still returns real data
        if (sel_valid) begin
          rsp_data_d = ext_data;
          state_d    = RM_RESP;
`ifdef LSU_RMUX_TIMEOUT_EN
          err_d      = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RM_RESP;
`endif
        end
      end
      RM_RESP: begin
        if (rsp_ready_i) begin
          state_d = RM_IDLE;
`ifdef LSU_RMUX_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = RM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RM_IDLE;
      sel_q      <= '0;
      off_q      <= '0;
      size_q     <= LS_BYTE;
      uns_q      <= 1'b0;
      rsp_data_q <= '0;
`ifdef LSU_RMUX_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rsp_data_q <= rsp_data_d;
`ifdef LSU_RMUX_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign req_ready_o = (state_q == RM_IDLE);
  assign rsp_valid_o = (state_q == RM_RESP);
  assign rsp_data_o  = rsp_data_q;
`ifdef LSU_RMUX_TIMEOUT_EN
  assign rsp_err_o   = err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_rdata_mux_8to1.sv
// Scoreboard bench for lsu_rdata_mux_8to1; timeout cases build only with
// LSU_RMUX_TIMEOUT_EN (DUT instantiated with TIMEOUT_CYCLES=4).
module tb_lsu_rdata_mux_8to1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       sel_i;
  logic [1:0]       byte_off_i;
  logic [1:0]       size_i;
  logic             unsigned_i;
  logic [7:0][31:0] data_i;
  logic [7:0]       data_valid_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic             rsp_err_o;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] sb_q[$];  // {err, data}

  lsu_rdata_mux_8to1 #(.DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .sel_i(sel_i), .byte_off_i(byte_off_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .data_i(data_i), .data_valid_i(data_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    case (sz)
      2'd0: begin
        s = w >> (8 * off);
        return uns ? {24'h0, s[7:0]} : 32'($signed(s[7:0]));
      end
      2'd1: begin
        s = w >> (16 * off[1]);
        return uns ? {16'h0, s[15:0]} : 32'($signed(s[15:0]));
      end
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // response monitor: every handshake pops one expected entry
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (sb_q.size() == 0) chk("spurious_rsp", {31'h0, rsp_valid_o}, 32'h0);
      else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("rsp_data", rsp_data_o, e[31:0]);
        chk("rsp_err", {31'h0, rsp_err_o}, {31'h0, e[32]});
      end
    end
  end

  // issue one load, deliver data after lat idle WAIT cycles; ends with rsp_valid_o up
  task automatic do_load(input logic [2:0] sel, input logic [1:0] off, input logic [1:0] sz,
                         input logic uns, input logic [31:0] w, input int lat, input bit noise);
    req_valid_i = 1'b1; sel_i = sel; byte_off_i = off; size_i = sz; unsigned_i = uns;
    data_valid_i[sel] = 1'b1;  // ignored: request not yet accepted
    data_i[sel] = ~w;
    chk("req_ready_idle", {31'h0, req_ready_o}, 32'h1);
    tick();
    req_valid_i = 1'b0; data_valid_i = '0;
    sb_q.push_back({1'b0, model(w, off, sz, uns)});
    chk("req_ready_wait", {31'h0, req_ready_o}, 32'h0);
    for (int i = 0; i < lat; i++) begin
      if (noise) begin
        data_valid_i[sel + 3'd1] = 1'b1;
        data_i[sel + 3'd1] = 32'hDEAD_BEEF;
      end
      tick();
      data_valid_i = '0;
      chk("no_rsp_in_wait", {31'h0, rsp_valid_o}, 32'h0);
    end
    data_valid_i[sel] = 1'b1; data_i[sel] = w;
    tick();
    data_valid_i = '0; data_i[sel] = 32'h0;
    chk("rsp_latency", {31'h0, rsp_valid_o}, 32'h1);
  endtask

  task automatic finish_rsp();
    int k = 0;
    rsp_ready_i = 1'b1;
    while (rsp_valid_o && k < 20) begin tick(); k++; end
    chk("rsp_single_cycle", k, 1);
    chk("back_to_idle", {31'h0, req_ready_o}, 32'h1);
  endtask

  initial begin
    logic [31:0] held;
    rst_i = 1'b1; req_valid_i = 1'b0; sel_i = '0; byte_off_i = '0; size_i = '0;
    unsigned_i = 1'b0; data_i = '0; data_valid_i = '0; rsp_ready_i = 1'b1;
    #12;
    chk("rst_req_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_rsp_data", rsp_data_o, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err_o}, 32'h0);
    rst_i = 1'b0;
    tick();

    // directed extraction cases
    do_load(3'd3, 2'd0, 2'd2, 1'b0, 32'hCAFE_1234, 0, 1'b0); finish_rsp();
    do_load(3'd5, 2'd2, 2'd0, 1'b0, 32'h0080_FF00, 0, 1'b0); finish_rsp();
    do_load(3'd5, 2'd2, 2'd0, 1'b1, 32'h0080_FF00, 1, 1'b0); finish_rsp();
    do_load(3'd1, 2'd3, 2'd1, 1'b0, 32'h8001_7FFF, 2, 1'b1); finish_rsp();
    do_load(3'd7, 2'd2, 2'd3, 1'b0, 32'h1234_5678, 0, 1'b0); finish_rsp();

    // backpressure: hold RESP for 5 cycles with a competing request
    rsp_ready_i = 1'b0;
    do_load(3'd6, 2'd1, 2'd0, 1'b1, 32'h0000_A500, 0, 1'b0);
    req_valid_i = 1'b1; sel_i = 3'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'h0, rsp_valid_o}, 32'h1);
      chk("bp_data", rsp_data_o, 32'h0000_00A5);
      chk("bp_req_ready", {31'h0, req_ready_o}, 32'h0);
    end
    rsp_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    chk("bp_release", {31'h0, rsp_valid_o}, 32'h0);
    chk("bp_no_accept", {31'h0, req_ready_o}, 32'h1);
    tick();
    chk("bp_still_idle", {31'h0, req_ready_o}, 32'h1);

    // random loads
    for (int i = 0; i < 8; i++) begin
      do_load(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
              1'($urandom_range(1)), $urandom, int'($urandom_range(3)), 1'b1);
      finish_rsp();
    end

    // async reset mid-WAIT discards the load
    held = rsp_data_o;
    req_valid_i = 1'b1; sel_i = 3'd2; byte_off_i = 2'd0; size_i = 2'd2;
    tick();
    req_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_req_ready", {31'h0, req_ready_o}, 32'h1);
    chk("arst_rsp_data", rsp_data_o, 32'h0);
    if (held != 32'h0) chk("arst_cleared_nonzero", rsp_data_o, 32'h0);
    #1 rst_i = 1'b0;
    tick();
    data_valid_i[2] = 1'b1; data_i[2] = 32'h5555_AAAA;
    tick();
    data_valid_i = '0;
    tick();
    chk("arst_late_valid", {31'h0, rsp_valid_o}, 32'h0);

`ifdef LSU_RMUX_TIMEOUT_EN
    // no valid: expires after 4 WAIT cycles
    req_valid_i = 1'b1; sel_i = 3'd4; size_i = 2'd2; rsp_ready_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    sb_q.push_back({1'b1, 32'h0});
    for (int i = 0; i < 3; i++) tick();
    chk("to_not_yet", {31'h0, rsp_valid_o}, 32'h0);
    tick();
    chk("to_valid", {31'h0, rsp_valid_o}, 32'h1);
    chk("to_err", {31'h0, rsp_err_o}, 32'h1);
    finish_rsp();
    chk("to_err_clear", {31'h0, rsp_err_o}, 32'h0);
    // valid on the expiry cycle wins
    do_load(3'd4, 2'd0, 2'd2, 1'b0, 32'h0BAD_F00D, 3, 1'b0);
    chk("to_race_err", {31'h0, rsp_err_o}, 32'h0);
    finish_rsp();
`endif

    tick(); tick();
    chk("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
